// File: rtl/jls_line_feeder.sv
// Frame sequencer and line buffer feeding the 8-pixel-per-cycle JPEG-LS source stage.
// Pairs each current-row word with the co-located previous-row word, then issues flush beats.
module jls_line_feeder #(
   parameter int unsigned MAX_WORDS    = 1024,
   parameter int unsigned FLUSH_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [9:0]  width,
   input  logic [15:0] height,
   output logic        busy,
   output logic        done,
   output logic        cfg_err,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [63:0] s_x,
   input  logic        dn_ready,
   output logic        src_rst,
   output logic        src_ena,
   output logic [63:0] src_x,
   output logic [63:0] src_b
);

   localparam int unsigned AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_RUN,
      ST_FLUSH,
      ST_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [9:0]     width_q, width_d;
   logic [15:0]    height_q, height_d;
   logic [9:0]     hpos_q, hpos_d;
   logic [15:0]    vpos_q, vpos_d;
   logic [FW-1:0]  flush_cnt_q, flush_cnt_d;
   logic           busy_q, done_q, cfg_err_q;
   logic           cfg_err_d;
   logic           lb_we;
   logic [AW-1:0]  lb_addr;
   logic [63:0]    linebuf [MAX_WORDS];

   assign lb_addr = hpos_q[AW-1:0];
   assign busy    = busy_q;
   assign done    = done_q;
   assign cfg_err = cfg_err_q;

   // Next-state, counter update and zero-latency handshake/source outputs.
   always_comb begin
      state_d     = state_q;
      width_d     = width_q;
      height_d    = height_q;
      hpos_d      = hpos_q;
      vpos_d      = vpos_q;
      flush_cnt_d = flush_cnt_q;
      cfg_err_d   = 1'b0;
      lb_we       = 1'b0;
      s_ready     = 1'b0;
      src_ena     = 1'b0;
      src_rst     = 1'b0;
      src_x       = '0;
      src_b       = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (32'(width) < MAX_WORDS) begin
                  width_d     = width;
                  height_d    = height;
                  hpos_d      = '0;
                  vpos_d      = '0;
                  flush_cnt_d = '0;
                  state_d     = ST_INIT;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         ST_INIT: begin
            src_rst = 1'b1;
            state_d = (height_q != 16'd0) ? ST_RUN : ST_FLUSH;
         end
         ST_RUN: begin
            s_ready = dn_ready;
            src_ena = s_valid & dn_ready;
            src_x   = s_x;
            // Asynchronous read happens before the clocked write, so src_b sees the old word.
            src_b   = (vpos_q != 16'd0) ? linebuf[lb_addr] : '0;
            if (s_valid && dn_ready) begin
               lb_we = 1'b1;
               if (hpos_q == width_q) begin
                  hpos_d = '0;
                  if (vpos_q == height_q - 16'd1) begin
                     state_d = ST_FLUSH;
                  end else begin
                     vpos_d = vpos_q + 16'd1;
                  end
               end else begin
                  hpos_d = hpos_q + 10'd1;
               end
            end
         end
         ST_FLUSH: begin
            src_ena = dn_ready;
            if (dn_ready) begin
               if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  flush_cnt_d = flush_cnt_q + FW'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer state, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         width_q     <= '0;
         height_q    <= '0;
         hpos_q      <= '0;
         vpos_q      <= '0;
         flush_cnt_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         width_q     <= width_d;
         height_q    <= height_d;
         hpos_q      <= hpos_d;
         vpos_q      <= vpos_d;
         flush_cnt_q <= flush_cnt_d;
         busy_q      <= (state_d != ST_IDLE);
         done_q      <= (state_d == ST_DONE);
         cfg_err_q   <= cfg_err_d;
      end
   end

   // Line buffer write on every RUN beat; contents need no reset.
   always_ff @(posedge clk) begin
      if (lb_we) begin
         linebuf[lb_addr] <= s_x;
      end
   end

endmodule

// File: tb/tb_jls_line_feeder.sv
// Randomized bench for jls_line_feeder against a frame-level reference model.
module tb_jls_line_feeder;

   localparam int FC = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, start2 = 1'b0;
   logic [9:0]  width = '0;
   logic [15:0] height = '0;
   logic        s_valid = 1'b0, dn_ready = 1'b0;
   logic [63:0] s_x = '0;
   logic        busy, done, cfg_err, s_ready, src_rst, src_ena;
   logic [63:0] src_x, src_b;
   logic        busy2, done2, cfg_err2, s_ready2, src_rst2, src_ena2;
   logic [63:0] src_x2, src_b2;

   int total = 0;
   int bad   = 0;
   logic [63:0] frame_q[$];

   always #5 clk = ~clk;

   jls_line_feeder #(.MAX_WORDS(1024), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
      .busy(busy), .done(done), .cfg_err(cfg_err),
      .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .dn_ready(dn_ready),
      .src_rst(src_rst), .src_ena(src_ena), .src_x(src_x), .src_b(src_b)
   );

   jls_line_feeder #(.MAX_WORDS(512), .FLUSH_CYCLES(FC)) dut_small (
      .clk(clk), .rst(rst), .start(start2), .width(width), .height(height),
      .busy(busy2), .done(done2), .cfg_err(cfg_err2),
      .s_valid(s_valid), .s_ready(s_ready2), .s_x(s_x), .dn_ready(dn_ready),
      .src_rst(src_rst2), .src_ena(src_ena2), .src_x(src_x2), .src_b(src_b2)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic gen_frame(input int n);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back({$urandom, $urandom});
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_cfg"}, cfg_err, 1'b0);
      chk({tag, "_rdy"}, s_ready, 1'b0);
      chk({tag, "_srst"}, src_rst, 1'b0);
      chk({tag, "_ena"}, src_ena, 1'b0);
      chk({tag, "_x"}, src_x, 64'd0);
      chk({tag, "_b"}, src_b, 64'd0);
   endtask

   // Reference: beat k carries word k, paired with word k-(w+1) or zero on the
   // first line; then FC flush beats of zeros, then one done cycle.
   task automatic run_frame(input int w, input int h, input bit stall, input int abort_at);
      int  n = (w + 1) * h;
      int  idx = 0;
      int  fbeats = 0;
      int  cyc = 0;
      bit  seen_done = 1'b0;
      bit  aborted = 1'b0;
      logic [63:0] exp_b;

      @(posedge clk); #1;
      start = 1'b1; width = 10'(w); height = 16'(h); s_valid = 1'b0; dn_ready = 1'b1; rst = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; s_valid = 1'b1; s_x = {$urandom, $urandom};
      #1;
      chk("init_srst", src_rst, 1'b1);
      chk("init_ena", src_ena, 1'b0);
      chk("init_rdy", s_ready, 1'b0);
      chk("init_busy", busy, 1'b1);
      chk("init_cfg", cfg_err, 1'b0);

      while (!seen_done && !aborted && cyc < 20000) begin
         @(posedge clk); #1;
         cyc++;
         if (idx < n) begin
            dn_ready = stall ? ~dn_ready : 1'b1;
            s_valid  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            s_x      = frame_q[idx];
         end else if (fbeats < FC) begin
            dn_ready = stall ? ~dn_ready : 1'b1;
            s_valid  = 1'($urandom_range(0, 1));
            s_x      = {$urandom, $urandom};
         end else begin
            start   = 1'b1;
            s_valid = 1'b0;
         end
         rst = (abort_at >= 0) && (idx == abort_at);
         #1;
         if (idx < n) begin
            chk("run_rdy", s_ready, dn_ready);
            chk("run_ena", src_ena, s_valid & dn_ready);
            chk("run_done", done, 1'b0);
            chk("run_busy", busy, 1'b1);
            if (s_valid && dn_ready) begin
               exp_b = (idx > w) ? frame_q[idx - w - 1] : 64'd0;
               chk("run_x", src_x, frame_q[idx]);
               chk("run_b", src_b, exp_b);
               if (rst) aborted = 1'b1;
               idx++;
            end
         end else if (fbeats < FC) begin
            chk("fl_rdy", s_ready, 1'b0);
            chk("fl_ena", src_ena, dn_ready);
            chk("fl_done", done, 1'b0);
            chk("fl_busy", busy, 1'b1);
            if (dn_ready) begin
               chk("fl_x", src_x, 64'd0);
               chk("fl_b", src_b, 64'd0);
               fbeats++;
            end
         end else begin
            chk("done_pulse", done, 1'b1);
            chk("done_busy", busy, 1'b1);
            chk("done_ena", src_ena, 1'b0);
            seen_done = 1'b1;
         end
      end

      if (aborted) begin
         @(posedge clk); #1;
         rst = 1'b0; start = 1'b0; s_valid = 1'b1; dn_ready = 1'b1;
         #1;
         chk_idle_zero("abort");
      end else begin
         chk("frame_finished", seen_done, 1'b1);
         @(posedge clk); #1;
         start = 1'b0; s_valid = 1'b0;
         #1;
         chk("post_busy", busy, 1'b0);
         chk("post_done", done, 1'b0);
         chk("post_srst_start_ignored", src_rst, 1'b0);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1; rst = 1'b0; #1;
      chk_idle_zero("reset");

      gen_frame(6);
      run_frame(1, 3, 1'b0, -1);
      run_frame(1, 3, 1'b1, -1);

      gen_frame(2);
      run_frame(0, 2, 1'b0, -1);

      gen_frame(0);
      run_frame(0, 0, 1'b0, -1);

      // width 1023 rejected by the 512-word instance
      @(posedge clk); #1;
      width = 10'd1023; height = 16'd1; start2 = 1'b1; s_valid = 1'b0;
      @(posedge clk); #1;
      start2 = 1'b0; #1;
      chk("cfg_err_small", cfg_err2, 1'b1);
      chk("cfg_busy_small", busy2, 1'b0);
      chk("cfg_srst_small", src_rst2, 1'b0);
      chk("cfg_rdy_small", s_ready2, 1'b0);
      chk("cfg_ena_small", src_ena2, 1'b0);
      chk("cfg_done_small", done2, 1'b0);
      chk("cfg_x_small", src_x2, 64'd0);
      chk("cfg_b_small", src_b2, 64'd0);
      @(posedge clk); #2;
      chk("cfg_err_pulse", cfg_err2, 1'b0);
      chk("cfg_busy_after", busy2, 1'b0);

      // width 1023 accepted at full depth, across a line wrap
      gen_frame(2048);
      run_frame(1023, 2, 1'b0, -1);

      // abort at the third beat, then a clean rerun of the first frame
      gen_frame(6);
      run_frame(1, 3, 1'b0, 2);
      run_frame(1, 3, 1'b0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jls_line_feeder.md
Name: jls_line_feeder

Overview:
- Frame-level sequencer and line buffer in front of the 8-pixel-per-cycle JPEG-LS source stage.
- Accepts the raw current-row pixel stream over a valid/ready handshake and stores each line in an internal line buffer.
- Presents each current-row word with the co-located word of the previous row, and drives the source stage's enable and reset.
- After the last word, issues flush beats so the downstream pipeline drains, then signals done.

Parameters:
MAX_WORDS, 1024, line buffer depth in 8-pixel words; maximum supported width+1.
FLUSH_CYCLES, 16, number of enable beats issued after the last frame word.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  frame start pulse; sampled only in IDLE
width  input  10  words per line minus 1; latched at accepted start
height  input  16  lines per frame; latched at accepted start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of frame
cfg_err  output  1  one-cycle pulse when start is rejected for width >= MAX_WORDS
s_valid  input  1  upstream word valid
s_ready  output  1  upstream word accepted when s_valid & s_ready
s_x  input  64  8 pixels, pixel 1 in [7:0], pixel 8 in [63:56]
dn_ready  input  1  downstream may advance; low stalls everything
src_rst  output  1  reset to source stage; asserted only while src_ena is low
src_ena  output  1  source stage advance enable
src_x  output  64  current-row word, same packing as s_x
src_b  output  64  previous-row word at same horizontal position

Behaviour:
- States: IDLE, INIT, RUN, FLUSH, DONE.
- Reset:
  - State returns to IDLE; hpos, vpos and the flush counter clear.
  - All outputs are 0; line buffer contents are don't-care.
  - rst mid-frame aborts immediately, with no done pulse.
- IDLE:
  - start with width < MAX_WORDS: latch width and height, go to INIT.
  - start with width >= MAX_WORDS: pulse cfg_err, stay in IDLE.
- INIT (one cycle):
  - src_rst=1, src_ena=0, s_ready=0.
  - Next state is RUN if height != 0, else FLUSH.
- RUN:
  - s_ready = dn_ready.
  - src_ena = s_valid & dn_ready, combinational (zero latency).
  - src_x = s_x.
  - src_b = line buffer word at hpos when vpos != 0; 0 when vpos == 0.
- Line buffer access on each beat (src_ena in RUN):
  - Read-before-write to the same address: src_b shows the old word.
  - linebuf[hpos] is written with s_x.
- Counters, advancing only on beats:
  - hpos runs 0..width; at width it wraps to 0 and vpos increments.
  - Beat with vpos == height-1 and hpos == width is the last frame word; next state is FLUSH.
- No beat (s_valid=0 or dn_ready=0): counters, buffer and state hold; src_x/src_b are don't-care while src_ena=0.
- FLUSH:
  - s_ready=0; src_ena = dn_ready; src_x = src_b = 0.
  - Flush counter counts src_ena beats; after FLUSH_CYCLES beats, go to DONE.
  - Stalls (dn_ready=0) extend FLUSH; they do not drop beats.
- DONE (one cycle): done=1, go to IDLE. start in DONE is ignored.
- busy=1 in INIT, RUN, FLUSH and DONE.
- Widths:
  - hpos is 10 bit and vpos is 16 bit, with no overflow beyond the latched limits.
  - Frame words = (width+1)*height, max 1024*65535.
- Simultaneous events:
  - start together with rst: rst wins.
  - Upstream s_valid while dn_ready=0: held, not accepted.
- Upstream must present exactly (width+1)*height words per frame. Extra words wait for the next frame, because s_ready=0 outside RUN.

Test Plan:
- width=1, height=3, words X0..X5 streamed, dn_ready=1:
  - INIT shows src_rst=1 for 1 cycle.
  - 6 src_ena beats: line 0 has src_b=0; line 1 has src_b=X0,X1; line 2 has src_b=X2,X3.
  - Then 16 flush beats with src_x=0, done pulse, busy falls the cycle after done.
- Same frame with dn_ready toggling 1/0 every cycle and s_valid random:
  - Sequences of src_x and src_b on src_ena beats are identical to the first test.
  - s_ready=0 and src_ena=0 whenever dn_ready=0.
- width=0, height=2: line-0 beat has src_b=0; line-1 beat has src_b equal to the line-0 word; FLUSH follows.
- height=0: INIT → FLUSH directly, with exactly FLUSH_CYCLES beats and no s_ready.
- start with width=1023 and MAX_WORDS=1024: accepted. start with width=1023 and MAX_WORDS=512: cfg_err pulse, busy stays 0.
- rst asserted at the third beat of the first frame:
  - Next cycle: IDLE with all outputs 0 and no done.
  - A new frame started afterwards behaves exactly as in the first test.
